cell_free_list_arbiter: RTL and testbench

//  Owns the free list of shared packet-buffer cells (NUM_BLOCKS x BLOCK_BYTES) and shares it between

---
 rtl/cell_free_list_arbiter.sv | 135 +++++++++++++
 tb/tb_cell_free_list_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cell_free_list_arbiter.sv
// Free-list manager for shared packet-buffer cells: builds the list after reset, round-robin
// hands out one cell index per cycle to ingress ports, and queues returned cells at the tail.
module cell_free_list_arbiter #(
    parameter int  NUM_PORTS  = 4,
    parameter int  NUM_BLOCKS = 4096,
    localparam int ADDR_W     = $clog2(NUM_BLOCKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] alloc_req,
    output logic [NUM_PORTS-1:0] alloc_gnt,
    output logic [ADDR_W-1:0]    alloc_idx,
    input  logic                 free_valid,
    input  logic [ADDR_W-1:0]    free_idx,
    output logic                 free_ready,
    output logic                 init_done,
    output logic [ADDR_W:0]      free_count,
    output logic                 err_overflow
);
    localparam int                PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_W:0]   FULL = (ADDR_W+1)'(NUM_BLOCKS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BLOCKS - 1);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] entry [NUM_BLOCKS];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [ADDR_W-1:0] mem_wdata;

    logic              running;
    logic              full;
    logic              granted;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     cand;
    logic              free_fire;
    logic              free_accept;

    assign running      = (state_q == ST_RUN);
    assign full         = (count_q == FULL);
    assign free_ready   = running;
    assign init_done    = running;
    assign free_count   = count_q;
    assign err_overflow = err_q;
    assign free_fire    = free_valid & free_ready;
    // A free into a full list is only legal when a grant drains a slot in the same cycle.
    assign free_accept  = free_fire & (~full | granted);

    always_comb begin
        granted   = 1'b0;
        winner    = '0;
        cand      = '0;
        alloc_gnt = '0;
        if (running && count_q != '0) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
                if (!granted && alloc_req[cand]) begin
                    granted = 1'b1;
                    winner  = cand;
                end
            end
        end
        if (granted) alloc_gnt[winner] = 1'b1;
    end

    assign alloc_idx = granted ? entry[rd_ptr_q] : '0;

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        init_cnt_d = init_cnt_q;
        count_d    = count_q;
        rr_ptr_d   = rr_ptr_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr_q;
        mem_wdata  = free_idx;
        if (state_q == ST_INIT) begin
            mem_we     = 1'b1;
            mem_waddr  = init_cnt_q;
            mem_wdata  = init_cnt_q;
            init_cnt_d = init_cnt_q + ADDR_W'(1);
            if (init_cnt_q == LAST) begin
                state_d  = ST_RUN;
                count_d  = FULL;
                wr_ptr_d = '0;
            end
        end else begin
            if (granted) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                rr_ptr_d = PW'((int'(winner) + 1) % NUM_PORTS);
            end
            if (free_accept) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (free_fire && full && !granted) err_d = 1'b1;
            count_d = count_q + (ADDR_W+1)'(free_accept) - (ADDR_W+1)'(granted);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            init_cnt_q <= '0;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            init_cnt_q <= init_cnt_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            err_q      <= err_d;
        end
    end

    // Cell storage carries no reset; every entry is rewritten by INIT before any read.
    always_ff @(posedge clk) begin
        if (mem_we) entry[mem_waddr] <= mem_wdata;
    end
endmodule

// File: tb/tb_cell_free_list_arbiter.sv
// Directed bench for cell_free_list_arbiter: init timing, round-robin order, empty/full edges,
// simultaneous alloc+free, sticky overflow and mid-run reset; indices checked against a queue model.
module tb_cell_free_list_arbiter;
  localparam int NB = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  alloc_req;
  logic [3:0]  alloc_gnt;
  logic [11:0] alloc_idx;
  logic        free_valid;
  logic [11:0] free_idx;
  logic        free_ready;
  logic        init_done;
  logic [12:0] free_count;
  logic        err_overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];

  cell_free_list_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alloc_req    (alloc_req),
    .alloc_gnt    (alloc_gnt),
    .alloc_idx    (alloc_idx),
    .free_valid   (free_valid),
    .free_idx     (free_idx),
    .free_ready   (free_ready),
    .init_done    (init_done),
    .free_count   (free_count),
    .err_overflow (err_overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [3:0] req, input logic fv, input logic [11:0] fi);
    alloc_req  = req;
    free_valid = fv;
    free_idx   = fi;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // scoreboard
  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NB; i++) exp_q.push_back(12'(i));
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] gnt);
    logic [11:0] e;
    chk({tag, "_gnt"}, 32'(alloc_gnt), 32'(gnt));
    if (exp_q.size() == 0) begin
      chk({tag, "_model_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_idx"}, 32'(alloc_idx), 32'(e));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},   32'(alloc_gnt),    32'd0);
    chk({tag, "_idx"},   32'(alloc_idx),    32'd0);
    chk({tag, "_ready"}, 32'(free_ready),   32'd0);
    chk({tag, "_done"},  32'(init_done),    32'd0);
    chk({tag, "_count"}, 32'(free_count),   32'd0);
    chk({tag, "_err"},   32'(err_overflow), 32'd0);
  endtask

  initial begin
    int bad;
    int cyc;
    logic [11:0] e;

    rst_n = 1'b0;
    alloc_req = '0;
    free_valid = 1'b0;
    free_idx = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_zero("reset");

    // T1: init lasts exactly NB cycles, no grants while building the list
    rst_n = 1'b1;
    drive(4'b1111, 1'b0, 12'd0);
    model_reset();
    bad = 0;
    for (int c = 0; c < NB; c++) begin
      if (alloc_gnt !== 4'b0000 || init_done !== 1'b0 || free_ready !== 1'b0) bad++;
      step();
    end
    chk("t1_quiet_during_init", 32'(bad), 32'd0);
    chk("t1_init_done", 32'(init_done), 32'd1);
    chk("t1_free_ready", 32'(free_ready), 32'd1);
    chk("t1_count", 32'(free_count), 32'd4096);

    // T2: all ports requesting rotate 0,1,2,3,0
    expect_grant("t2_c0", 4'b0001); step();
    expect_grant("t2_c1", 4'b0010); step();
    expect_grant("t2_c2", 4'b0100); step();
    expect_grant("t2_c3", 4'b1000); step();
    expect_grant("t2_c4", 4'b0001); step();
    chk("t2_count", 32'(free_count), 32'd4091);

    // T3: park rr_ptr at 0 via port 3, then alternate ports 1 and 3
    drive(4'b1000, 1'b0, 12'd0);
    expect_grant("t3_park", 4'b1000); step();
    drive(4'b1010, 1'b0, 12'd0);
    expect_grant("t3_c0", 4'b0010); step();
    expect_grant("t3_c1", 4'b1000); step();
    expect_grant("t3_c2", 4'b0010); step();
    chk("t3_count", 32'(free_count), 32'd4087);

    // T4: drain the list, then check empty and no same-cycle bypass
    drive(4'b0001, 1'b0, 12'd0);
    bad = 0;
    cyc = exp_q.size();
    for (int k = 0; k < cyc; k++) begin
      e = exp_q.pop_front();
      if (alloc_gnt !== 4'b0001 || alloc_idx !== e) bad++;
      step();
    end
    chk("t4_drain_seq", 32'(bad), 32'd0);
    chk("t4_count_zero", 32'(free_count), 32'd0);
    chk("t4_empty_gnt", 32'(alloc_gnt), 32'd0);
    drive(4'b0001, 1'b1, 12'd7);
    chk("t4_no_bypass", 32'(alloc_gnt), 32'd0);
    chk("t4_free_ready", 32'(free_ready), 32'd1);
    exp_q.push_back(12'd7);
    step();
    drive(4'b0001, 1'b0, 12'd0);
    chk("t4_refill_idx7", 32'(alloc_idx), 32'd7);
    expect_grant("t4_refill", 4'b0001);
    step();
    drive(4'b0000, 1'b0, 12'd0);
    chk("t4_count_after", 32'(free_count), 32'd0);

    // T5: simultaneous alloc + free keeps count; freed index goes to the tail
    drive(4'b0000, 1'b1, 12'd10); exp_q.push_back(12'd10); step();
    drive(4'b0000, 1'b1, 12'd20); exp_q.push_back(12'd20); step();
    drive(4'b0000, 1'b1, 12'd30); exp_q.push_back(12'd30); step();
    drive(4'b0000, 1'b1, 12'd40); exp_q.push_back(12'd40); step();
    drive(4'b0000, 1'b1, 12'd50); exp_q.push_back(12'd50); step();
    drive(4'b0000, 1'b0, 12'd0);
    chk("t5_count5", 32'(free_count), 32'd5);
    drive(4'b0001, 1'b1, 12'd100);
    chk("t5_simul_idx10", 32'(alloc_idx), 32'd10);
    expect_grant("t5_simul", 4'b0001);
    exp_q.push_back(12'd100);
    step();
    drive(4'b0000, 1'b0, 12'd0);
    chk("t5_count_still5", 32'(free_count), 32'd5);
    drive(4'b0001, 1'b0, 12'd0);
    for (int k = 0; k < 4; k++) begin
      expect_grant("t5_drain", 4'b0001);
      step();
    end
    chk("t5_idx100_last", 32'(alloc_idx), 32'd100);
    expect_grant("t5_last", 4'b0001);
    step();
    drive(4'b0000, 1'b0, 12'd0);
    chk("t5_count_zero", 32'(free_count), 32'd0);

    // T6: refill to full, overflow is sticky, full+grant free is legal
    bad = 0;
    for (int i = 0; i < NB; i++) begin
      drive(4'b0000, 1'b1, 12'(i));
      if (free_ready !== 1'b1) bad++;
      exp_q.push_back(12'(i));
      step();
    end
    drive(4'b0000, 1'b0, 12'd0);
    chk("t6_refill_ready", 32'(bad), 32'd0);
    chk("t6_count_full", 32'(free_count), 32'd4096);
    chk("t6_err_clear", 32'(err_overflow), 32'd0);
    drive(4'b0000, 1'b1, 12'd3);
    step();
    drive(4'b0000, 1'b0, 12'd0);
    chk("t6_err_set", 32'(err_overflow), 32'd1);
    chk("t6_count_hold", 32'(free_count), 32'd4096);
    drive(4'b0001, 1'b1, 12'd9);
    chk("t6_full_grant_idx0", 32'(alloc_idx), 32'd0);
    expect_grant("t6_full_grant", 4'b0001);
    exp_q.push_back(12'd9);
    step();
    drive(4'b0000, 1'b0, 12'd0);
    chk("t6_count_after_legal", 32'(free_count), 32'd4096);
    step();
    chk("t6_err_sticky", 32'(err_overflow), 32'd1);

    // mid-run reset: outputs clear asynchronously, list rebuilt from scratch
    drive(4'b0001, 1'b0, 12'd0);
    chk("t6_pre_reset_gnt", 32'(alloc_gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async_reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    while (alloc_gnt === 4'b0000 && cyc < 5000) begin
      step();
      cyc++;
    end
    chk("t6_reinit_cycles", 32'(cyc), 32'd4096);
    chk("t6_reinit_idx0", 32'(alloc_idx), 32'd0);
    expect_grant("t6_reinit", 4'b0001);
    chk("t6_reinit_err", 32'(err_overflow), 32'd0);
    chk("t6_reinit_count", 32'(free_count), 32'd4096);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
